// File: rtl/io_channel_initiator.sv
// io_channel_initiator: host end of one device's IO channel.
// Accepts a single CPU IO command, forwards it on the IOOut channel and,
// when a response is requested, collects the IOIn response and hands it to
// the CPU writeback path. One transaction is outstanding at a time.
// Optional macro IO_TIMEOUT_EN bounds the response wait to TIMEOUTCYCLES
// enabled cycles and writes back TIMEOUTVALUE to the command tag on expiry.
module io_channel_initiator #(
    parameter int                      DATABITWIDTH  = 16,
    parameter int                      TIMEOUTCYCLES = 1024,
    parameter logic [DATABITWIDTH-1:0] TIMEOUTVALUE  = {DATABITWIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    async_rst,
    input  logic                    clk_en,
    input  logic                    CommandREQ,
    output logic                    CommandACK,
    input  logic [3:0]              MinorOpcodeIn,
    input  logic [DATABITWIDTH-1:0] CommandDataIn,
    input  logic [3:0]              CommandDestReg,
    output logic                    IOOut_REQ,
    input  logic                    IOOut_ACK,
    output logic                    IOOut_ResponseRequested,
    output logic [3:0]              IOOut_DestReg,
    output logic [DATABITWIDTH-1:0] IOOut_Data,
    input  logic                    IOIn_REQ,
    output logic                    IOIn_ACK,
    input  logic                    IOIn_RegResponseFlag,
    input  logic                    IOIn_MemResponseFlag,
    input  logic [3:0]              IOIn_DestReg,
    input  logic [DATABITWIDTH-1:0] IOIn_Data,
    output logic                    WritebackREQ,
    input  logic                    WritebackACK,
    output logic [3:0]              WritebackDestReg,
    output logic [DATABITWIDTH-1:0] WritebackData,
    output logic                    WritebackMemFlag,
    output logic                    Busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RSP  = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic                    rsp_req_q;
    logic [3:0]              cmd_dest_q;
    logic [DATABITWIDTH-1:0] cmd_data_q;
    logic [3:0]              wb_dest_q;
    logic [DATABITWIDTH-1:0] wb_data_q;
    logic                    wb_mem_q;

    logic                    cmd_fire;
    logic                    out_fire;
    logic                    in_fire;
    logic                    wb_fire;
    logic                    rsp_valid;
    logic                    timeout_hit;

    // Transfers happen only on enabled cycles in the state that owns the ACK.
    assign cmd_fire  = clk_en & CommandREQ & (state_q == IDLE);
    assign out_fire  = clk_en & IOOut_ACK  & (state_q == SEND);
    assign in_fire   = clk_en & IOIn_REQ   & (state_q == WAIT_RSP);
    assign wb_fire   = clk_en & WritebackACK & (state_q == WRITEBACK);
    // A response with neither flag set is consumed without a writeback.
    assign rsp_valid = IOIn_RegResponseFlag | IOIn_MemResponseFlag;

`ifdef IO_TIMEOUT_EN
    localparam int              CNT_W   = (TIMEOUTCYCLES > 1) ? $clog2(TIMEOUTCYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUTCYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // A same-cycle response takes priority over the timeout.
    assign timeout_hit = clk_en & (state_q == WAIT_RSP) & ~IOIn_REQ & (wait_cnt_q == CNT_MAX);

    // Wait counter: zero outside WAIT_RSP, counts enabled WAIT_RSP cycles, saturates.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            wait_cnt_q <= '0;
        end else if (clk_en) begin
            if (state_q != WAIT_RSP) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != CNT_MAX) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^{TIMEOUTVALUE, TIMEOUTCYCLES[0]};
`endif

    // Opcode bits [2:0] carry no meaning for the channel.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^MinorOpcodeIn[2:0];

    // State register.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (cmd_fire) state_d = SEND;
            SEND:      if (out_fire) state_d = rsp_req_q ? WAIT_RSP : IDLE;
            WAIT_RSP: begin
                if (in_fire) begin
                    state_d = rsp_valid ? WRITEBACK : IDLE;
                end else if (timeout_hit) begin
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: if (wb_fire) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Command and response payload latches.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            rsp_req_q  <= 1'b0;
            cmd_dest_q <= '0;
            cmd_data_q <= '0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            wb_mem_q   <= 1'b0;
        end else begin
            if (cmd_fire) begin
                rsp_req_q  <= MinorOpcodeIn[3];
                cmd_dest_q <= CommandDestReg;
                cmd_data_q <= CommandDataIn;
            end
            if (in_fire) begin
                // Both flags set counts as a register response.
                wb_dest_q <= IOIn_DestReg;
                wb_data_q <= IOIn_Data;
                wb_mem_q  <= IOIn_MemResponseFlag & ~IOIn_RegResponseFlag;
            end else if (timeout_hit) begin
                wb_dest_q <= cmd_dest_q;
                wb_data_q <= TIMEOUTVALUE;
                wb_mem_q  <= 1'b0;
            end
        end
    end

    // CommandACK is also held low while reset is asserted.
    assign CommandACK              = async_rst & (state_q == IDLE);
    assign IOOut_REQ               = (state_q == SEND);
    assign IOIn_ACK                = (state_q == WAIT_RSP);
    assign WritebackREQ            = (state_q == WRITEBACK);
    assign Busy                    = (state_q != IDLE);
    assign IOOut_ResponseRequested = rsp_req_q;
    assign IOOut_DestReg           = cmd_dest_q;
    assign IOOut_Data              = cmd_data_q;
    assign WritebackDestReg        = wb_dest_q;
    assign WritebackData           = wb_data_q;
    assign WritebackMemFlag        = wb_mem_q;

endmodule

// File: tb/tb_io_channel_initiator.sv
// Directed testbench for io_channel_initiator (TIMEOUTCYCLES = 8).
module tb_io_channel_initiator;

    logic        clk = 1'b0;
    logic        async_rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        CommandREQ = 1'b0;
    logic        CommandACK;
    logic [3:0]  MinorOpcodeIn = '0;
    logic [15:0] CommandDataIn = '0;
    logic [3:0]  CommandDestReg = '0;
    logic        IOOut_REQ;
    logic        IOOut_ACK = 1'b0;
    logic        IOOut_ResponseRequested;
    logic [3:0]  IOOut_DestReg;
    logic [15:0] IOOut_Data;
    logic        IOIn_REQ = 1'b0;
    logic        IOIn_ACK;
    logic        IOIn_RegResponseFlag = 1'b0;
    logic        IOIn_MemResponseFlag = 1'b0;
    logic [3:0]  IOIn_DestReg = '0;
    logic [15:0] IOIn_Data = '0;
    logic        WritebackREQ;
    logic        WritebackACK = 1'b0;
    logic [3:0]  WritebackDestReg;
    logic [15:0] WritebackData;
    logic        WritebackMemFlag;
    logic        Busy;

    int n_assert = 0;
    int n_fail   = 0;

    io_channel_initiator #(
        .DATABITWIDTH (16),
        .TIMEOUTCYCLES(8),
        .TIMEOUTVALUE (16'hFFFF)
    ) dut (
        .clk                    (clk),
        .async_rst              (async_rst),
        .clk_en                 (clk_en),
        .CommandREQ             (CommandREQ),
        .CommandACK             (CommandACK),
        .MinorOpcodeIn          (MinorOpcodeIn),
        .CommandDataIn          (CommandDataIn),
        .CommandDestReg         (CommandDestReg),
        .IOOut_REQ              (IOOut_REQ),
        .IOOut_ACK              (IOOut_ACK),
        .IOOut_ResponseRequested(IOOut_ResponseRequested),
        .IOOut_DestReg          (IOOut_DestReg),
        .IOOut_Data             (IOOut_Data),
        .IOIn_REQ               (IOIn_REQ),
        .IOIn_ACK               (IOIn_ACK),
        .IOIn_RegResponseFlag   (IOIn_RegResponseFlag),
        .IOIn_MemResponseFlag   (IOIn_MemResponseFlag),
        .IOIn_DestReg           (IOIn_DestReg),
        .IOIn_Data              (IOIn_Data),
        .WritebackREQ           (WritebackREQ),
        .WritebackACK           (WritebackACK),
        .WritebackDestReg       (WritebackDestReg),
        .WritebackData          (WritebackData),
        .WritebackMemFlag       (WritebackMemFlag),
        .Busy                   (Busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one accepting edge, then drop it.
    task automatic issue(input logic [3:0] op, input logic [15:0] data, input logic [3:0] dest);
        CommandREQ     = 1'b1;
        MinorOpcodeIn  = op;
        CommandDataIn  = data;
        CommandDestReg = dest;
        tick();
        CommandREQ     = 1'b0;
    endtask

    // Device accepts the pending command on the next edge.
    task automatic dev_accept();
        IOOut_ACK = 1'b1;
        tick();
        IOOut_ACK = 1'b0;
    endtask

    task automatic respond(input logic reg_f, input logic mem_f, input logic [3:0] dest,
                           input logic [15:0] data);
        IOIn_REQ             = 1'b1;
        IOIn_RegResponseFlag = reg_f;
        IOIn_MemResponseFlag = mem_f;
        IOIn_DestReg         = dest;
        IOIn_Data            = data;
        tick();
        IOIn_REQ             = 1'b0;
        IOIn_RegResponseFlag = 1'b0;
        IOIn_MemResponseFlag = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_cmdack", CommandACK, 0);
        check("rst_busy", Busy, 0);
        check("rst_ioout_req", IOOut_REQ, 0);
        check("rst_wb_req", WritebackREQ, 0);
        check("rst_ioout_data", IOOut_Data, 0);
        tick();
        async_rst = 1'b1;
        tick();
        check("idle_cmdack", CommandACK, 1);

        // Write, no response
        IOOut_ACK = 1'b1;
        issue(4'h0, 16'h00A5, 4'd3);
        check("wr_ioout_req", IOOut_REQ, 1);
        check("wr_rr", IOOut_ResponseRequested, 0);
        check("wr_data", IOOut_Data, 16'h00A5);
        check("wr_dest", IOOut_DestReg, 3);
        check("wr_cmdack_busy", CommandACK, 0);
        tick();
        IOOut_ACK = 1'b0;
        check("wr_ioout_req_drop", IOOut_REQ, 0);
        check("wr_busy_drop", Busy, 0);
        check("wr_no_wb", WritebackREQ, 0);

        // Spurious response while idle
        IOIn_REQ = 1'b1;
        IOIn_RegResponseFlag = 1'b1;
        check("spur_ioin_ack", IOIn_ACK, 0);
        tick();
        check("spur_busy", Busy, 0);
        check("spur_cmdack", CommandACK, 1);
        IOIn_REQ = 1'b0;
        IOIn_RegResponseFlag = 1'b0;

        // Read with register response three cycles later
        issue(4'h8, 16'h0000, 4'd5);
        check("rd_rr", IOOut_ResponseRequested, 1);
        dev_accept();
        check("rd_ioin_ack", IOIn_ACK, 1);
        tick();
        tick();
        check("rd_still_wait", IOIn_ACK, 1);
        respond(1'b1, 1'b0, 4'd5, 16'h1234);
        check("rd_wb_req", WritebackREQ, 1);
        check("rd_wb_dest", WritebackDestReg, 5);
        check("rd_wb_data", WritebackData, 16'h1234);
        check("rd_wb_mem", WritebackMemFlag, 0);
        check("rd_ioin_ack_drop", IOIn_ACK, 0);
        WritebackACK = 1'b1;
        tick();
        WritebackACK = 1'b0;
        check("rd_busy_drop", Busy, 0);
        check("rd_wb_req_drop", WritebackREQ, 0);

        // Backpressure on both channels; memory response with a device tag
        issue(4'h8, 16'hBEEF, 4'd2);
        CommandREQ = 1'b1;
        CommandDataIn = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_ioout_req", IOOut_REQ, 1);
            check("bp_ioout_data", IOOut_Data, 16'hBEEF);
            check("bp_ioout_dest", IOOut_DestReg, 2);
            check("bp_cmdack", CommandACK, 0);
        end
        CommandREQ = 1'b0;
        dev_accept();
        respond(1'b0, 1'b1, 4'd9, 16'h5A5A);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_wb_req", WritebackREQ, 1);
            check("bp_wb_data", WritebackData, 16'h5A5A);
            check("bp_wb_dest", WritebackDestReg, 9);
            check("bp_wb_mem", WritebackMemFlag, 1);
            check("bp_wb_cmdack", CommandACK, 0);
        end
        // Clock enable low: an ACK is not a transfer
        clk_en = 1'b0;
        WritebackACK = 1'b1;
        tick();
        check("cen_hold_wb", WritebackREQ, 1);
        clk_en = 1'b1;
        tick();
        WritebackACK = 1'b0;
        check("cen_release_idle", Busy, 0);

        // Response with no flags is discarded
        issue(4'h8, 16'h0001, 4'd6);
        dev_accept();
        IOIn_REQ = 1'b1;
        check("disc_ioin_ack", IOIn_ACK, 1);
        tick();
        IOIn_REQ = 1'b0;
        check("disc_busy", Busy, 0);
        check("disc_no_wb", WritebackREQ, 0);

        // Both flags set is a register response
        issue(4'h8, 16'h0002, 4'd4);
        dev_accept();
        respond(1'b1, 1'b1, 4'd4, 16'hCAFE);
        check("both_wb_mem", WritebackMemFlag, 0);
        check("both_wb_data", WritebackData, 16'hCAFE);
        WritebackACK = 1'b1;
        tick();
        WritebackACK = 1'b0;

        // Reset in the middle of WAIT_RSP
        issue(4'h8, 16'h0BAD, 4'd8);
        dev_accept();
        check("mid_wait", IOIn_ACK, 1);
        #2;
        async_rst = 1'b0;
        #1;
        check("mid_rst_ioin_ack", IOIn_ACK, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_cmdack", CommandACK, 0);
        check("mid_rst_ioout_data", IOOut_Data, 0);
        check("mid_rst_ioout_dest", IOOut_DestReg, 0);
        tick();
        async_rst = 1'b1;
        tick();
        respond(1'b1, 1'b0, 4'd8, 16'h1111);
        check("post_rst_no_wb", WritebackREQ, 0);
        check("post_rst_idle", CommandACK, 1);

`ifdef IO_TIMEOUT_EN
        // Silent device: timeout after 8 waiting cycles
        issue(4'h8, 16'h0003, 4'd7);
        dev_accept();
        for (int i = 0; i < 7; i++) tick();
        check("to_still_wait", IOIn_ACK, 1);
        tick();
        check("to_wb_req", WritebackREQ, 1);
        check("to_wb_data", WritebackData, 16'hFFFF);
        check("to_wb_dest", WritebackDestReg, 7);
        check("to_wb_mem", WritebackMemFlag, 0);
        WritebackACK = 1'b1;
        tick();
        WritebackACK = 1'b0;

        // Response on the eighth cycle wins over the timeout
        issue(4'h8, 16'h0004, 4'd7);
        dev_accept();
        for (int i = 0; i < 7; i++) tick();
        respond(1'b1, 1'b0, 4'd1, 16'h4321);
        check("to_race_data", WritebackData, 16'h4321);
        check("to_race_dest", WritebackDestReg, 1);
        WritebackACK = 1'b1;
        tick();
        WritebackACK = 1'b0;
        check("to_race_idle", Busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
